// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file sequencer.
// Holds the instruction encoding (field bit positions, opcodes), the
// sequencer state encoding, the decode class enum and datapath widths.
package rf_pkg;

  localparam int REG_W      = 9;
  localparam int ADDR_W     = 2;
  localparam int OP_W       = 3;
  localparam int INSTR_BITS = 10;

  // Field bit positions inside the instruction word.
  localparam int OP_MSB   = 9;
  localparam int OP_LSB   = 7;
  localparam int DST_MSB  = 6;
  localparam int DST_LSB  = 5;
  localparam int SRC0_MSB = 4;
  localparam int SRC0_LSB = 3;
  localparam int SRC1_MSB = 2;
  localparam int SRC1_LSB = 1;
  localparam int FLAG_BIT = 0;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_OR  = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_LDI = 3'b110;
  localparam logic [OP_W-1:0] OP_SYS = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_IMM    = 3'd2,
    ST_READ   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_CLR    = 3'd6,
    ST_HALT   = 3'd7
  } seq_state_t;

  // What the DECODE state does with an instruction.
  typedef enum logic [2:0] {
    CL_NOP  = 3'd0,
    CL_ALU  = 3'd1,
    CL_LDI  = 3'd2,
    CL_HALT = 3'd3,
    CL_CLR  = 3'd4
  } instr_class_t;

endpackage

// File: rtl/rf_seq_decode.sv
// rf_seq_decode: combinational field extraction for the sequencer.
// Ports:
//   i_instr   - latched instruction word
//   o_op      - opcode field
//   o_dst     - destination register
//   o_src0    - source register 0
//   o_src1    - source register 1
//   o_class   - what the sequencer should do next with this word
module rf_seq_decode
  import rf_pkg::*;
(
  input  logic [INSTR_BITS-1:0] i_instr,
  output logic [OP_W-1:0]       o_op,
  output logic [ADDR_W-1:0]     o_dst,
  output logic [ADDR_W-1:0]     o_src0,
  output logic [ADDR_W-1:0]     o_src1,
  output instr_class_t          o_class
);

  logic w_flag;

  assign o_op   = i_instr[OP_MSB:OP_LSB];
  assign o_dst  = i_instr[DST_MSB:DST_LSB];
  assign o_src0 = i_instr[SRC0_MSB:SRC0_LSB];
  assign o_src1 = i_instr[SRC1_MSB:SRC1_LSB];
  assign w_flag = i_instr[FLAG_BIT];

  // The system opcode splits on the flag bit: 0 halts, 1 clears the file.
  always_comb begin
    o_class = CL_NOP;
    case (o_op)
      OP_NOP:                                 o_class = CL_NOP;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT:  o_class = CL_ALU;
      OP_LDI:                                 o_class = CL_LDI;
      OP_SYS:                                 o_class = w_flag ? CL_CLR : CL_HALT;
      default:                                o_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/rf_seq_ctrl.sv
// rf_seq_ctrl: multi-cycle sequencer for the 4x9-bit register file and ALU.
// Accepts instruction words over valid/ready, decodes them and steps
// through read, execute and write-back. Every output is registered.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   instr_valid/ready     - instruction (or LDI immediate) handshake
//   instr_data            - instruction or immediate word
//   start                 - leaves HALT
//   rf_rd0/rd1_addr       - register file read addresses
//   rf_wr_addr, rf_wr_en  - register file write port control
//   rf_clr                - register file clear request
//   alu_op                - ALU operation select
//   imm_sel, imm_data     - write-back source select and LDI immediate
//   busy, halted          - status
//   retired_cnt           - completed instruction count (wraps)
module rf_seq_ctrl
  import rf_pkg::*;
#(
  parameter int INSTR_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               start,
  output logic [ADDR_W-1:0]  rf_rd0_addr,
  output logic [ADDR_W-1:0]  rf_rd1_addr,
  output logic [ADDR_W-1:0]  rf_wr_addr,
  output logic               rf_wr_en,
  output logic               rf_clr,
  output logic [OP_W-1:0]    alu_op,
  output logic               imm_sel,
  output logic [REG_W-1:0]   imm_data,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
);

  seq_state_t         r_state;
  logic [INSTR_W-1:0] r_instr;
  logic               r_ready;
  logic [ADDR_W-1:0]  r_rd0;
  logic [ADDR_W-1:0]  r_rd1;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic               r_wr_en;
  logic               r_clr;
  logic [OP_W-1:0]    r_alu_op;
  logic               r_imm_sel;
  logic [REG_W-1:0]   r_imm_data;
  logic               r_busy;
  logic               r_halted;
  logic [CNT_W-1:0]   r_retired;

  logic [OP_W-1:0]    w_op;
  logic [ADDR_W-1:0]  w_dst;
  logic [ADDR_W-1:0]  w_src0;
  logic [ADDR_W-1:0]  w_src1;
  instr_class_t       w_class;
  logic               w_xfer;

  rf_seq_decode u_decode (
    .i_instr (r_instr[INSTR_BITS-1:0]),
    .o_op    (w_op),
    .o_dst   (w_dst),
    .o_src0  (w_src0),
    .o_src1  (w_src1),
    .o_class (w_class)
  );

  // r_ready is only ever set when entering IDLE or IMM, so a transfer
  // can only happen in those two states.
  assign w_xfer = instr_valid & r_ready;

  // Single state machine; every output is updated on the transition into
  // the state that owns it, so outputs line up with the state they
  // describe. Ready comes up one cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_instr    <= '0;
      r_ready    <= 1'b0;
      r_rd0      <= '0;
      r_rd1      <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_clr      <= 1'b0;
      r_alu_op   <= '0;
      r_imm_sel  <= 1'b0;
      r_imm_data <= '0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_retired  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_instr <= instr_data;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_DECODE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_DECODE: begin
          case (w_class)
            CL_ALU: begin
              r_rd0   <= w_src0;
              r_rd1   <= w_src1;
              r_state <= ST_READ;
            end
            CL_LDI: begin
              r_ready <= 1'b1;
              r_state <= ST_IMM;
            end
            CL_HALT: begin
              r_halted  <= 1'b1;
              r_busy    <= 1'b0;
              r_retired <= r_retired + 1'b1;
              r_state   <= ST_HALT;
            end
            CL_CLR: begin
              r_clr   <= 1'b1;
              r_state <= ST_CLR;
            end
            default: begin
              r_ready   <= 1'b1;
              r_busy    <= 1'b0;
              r_retired <= r_retired + 1'b1;
              r_state   <= ST_IDLE;
            end
          endcase
        end
        ST_IMM: begin
          if (w_xfer) begin
            r_imm_data <= instr_data[REG_W-1:0];
            r_imm_sel  <= 1'b1;
            r_wr_en    <= 1'b1;
            r_wr_addr  <= w_dst;
            r_ready    <= 1'b0;
            r_state    <= ST_WB;
          end
        end
        ST_READ: begin
          r_alu_op <= w_op;
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_dst;
          r_state   <= ST_WB;
        end
        ST_WB: begin
          r_wr_en   <= 1'b0;
          r_imm_sel <= 1'b0;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
          r_retired <= r_retired + 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_CLR: begin
          r_clr     <= 1'b0;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
          r_retired <= r_retired + 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_HALT: begin
          if (start) begin
            r_halted <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign rf_rd0_addr = r_rd0;
  assign rf_rd1_addr = r_rd1;
  assign rf_wr_addr  = r_wr_addr;
  assign rf_wr_en    = r_wr_en;
  assign rf_clr      = r_clr;
  assign alu_op      = r_alu_op;
  assign imm_sel     = r_imm_sel;
  assign imm_data    = r_imm_data;
  assign busy        = r_busy;
  assign halted      = r_halted;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// tb_rf_seq_ctrl: directed bench for rf_seq_ctrl with hand-computed
// expectations. The DUT uses a 4-bit retired counter so wrap is reachable.
module tb_rf_seq_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [9:0]       instr_data;
  logic             start;
  logic [1:0]       rf_rd0_addr;
  logic [1:0]       rf_rd1_addr;
  logic [1:0]       rf_wr_addr;
  logic             rf_wr_en;
  logic             rf_clr;
  logic [2:0]       alu_op;
  logic             imm_sel;
  logic [8:0]       imm_data;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retired_cnt;

  int assertCount = 0;
  int failCount   = 0;
  int wrEnCount   = 0;
  int clrCount    = 0;
  int bothHigh    = 0;
  int expRetired  = 0;

  localparam logic [9:0] W_NOP  = 10'b000_00_00_00_0;
  localparam logic [9:0] W_LDI2 = 10'b110_10_00_00_0;
  localparam logic [9:0] W_ADD  = 10'b001_11_01_10_0;
  localparam logic [9:0] W_SUB  = 10'b010_01_10_11_0;
  localparam logic [9:0] W_CLR  = 10'b111_00_00_00_1;
  localparam logic [9:0] W_HALT = 10'b111_00_00_00_0;

  rf_seq_ctrl #(.INSTR_W(10), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .start       (start),
    .rf_rd0_addr (rf_rd0_addr),
    .rf_rd1_addr (rf_rd1_addr),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_en    (rf_wr_en),
    .rf_clr      (rf_clr),
    .alu_op      (alu_op),
    .imm_sel     (imm_sel),
    .imm_data    (imm_data),
    .busy        (busy),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write and clear pulses as the register file would see them.
  always @(posedge clk) begin
    if (rf_wr_en)           wrEnCount <= wrEnCount + 1;
    if (rf_clr)             clrCount  <= clrCount + 1;
    if (rf_wr_en && rf_clr) bothHigh  <= bothHigh + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the DUT is ready to accept.
  task automatic waitReady(input string tag);
    int n = 0;
    while (!instr_ready && n < 50) begin
      tick();
      n++;
    end
    if (!instr_ready) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  // Present a word, wait for acceptance, return one cycle after transfer.
  task automatic applyStimulus(input logic [9:0] word, input string tag);
    instr_valid = 1'b1;
    instr_data  = word;
    waitReady(tag);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int wrBase;
  int clrBase;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_data = '0; start = 1'b0;
    tick();
    checkOutput("rst_ready", instr_ready, 0);
    checkOutput("rst_outs", {rf_wr_en, rf_clr, imm_sel, busy, halted, alu_op, rf_wr_addr}, 0);
    doReset();

    // 1: reset during EXEC of an ADD aborts with no write
    wrBase = wrEnCount;
    applyStimulus(W_ADD, "t1_add");
    tick();
    tick();
    checkOutput("t1_exec_aluop", alu_op, 3'b001);
    rst_n = 1'b0;
    #1;
    checkOutput("t1_rst_outs", {rf_rd0_addr, rf_rd1_addr, rf_wr_addr, rf_wr_en, rf_clr,
                                alu_op, imm_sel, imm_data, busy, halted, instr_ready}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("t1_retired", retired_cnt, 0);
    checkOutput("t1_no_write", wrEnCount - wrBase, 0);

    // 2: LDI r2 with a 3-cycle gap before the immediate
    wrBase = wrEnCount;
    applyStimulus(W_LDI2, "t2_ldi");
    checkOutput("t2_decode_ready", instr_ready, 0);
    tick();
    checkOutput("t2_imm_ready_a", instr_ready, 1);
    tick();
    tick();
    tick();
    checkOutput("t2_imm_ready_b", instr_ready, 1);
    instr_valid = 1'b1;
    instr_data  = 10'h1A5;
    tick();
    instr_valid = 1'b0;
    checkOutput("t2_wb", {rf_wr_en, rf_wr_addr, imm_sel, imm_data}, {1'b1, 2'd2, 1'b1, 9'h1A5});
    tick();
    expRetired++;
    checkOutput("t2_after_wb", {rf_wr_en, imm_sel, instr_ready}, 3'b001);
    checkOutput("t2_retired", retired_cnt, expRetired[CNT_W-1:0]);
    checkOutput("t2_one_write", wrEnCount - wrBase, 1);

    // 3: ADD r3=r1+r2 with valid held high; cycle-exact
    instr_valid = 1'b1;
    instr_data  = W_ADD;
    waitReady("t3_add");
    tick();
    checkOutput("t3_c1", {instr_ready, busy, rf_wr_en}, 3'b010);
    tick();
    checkOutput("t3_c2_rd", {rf_rd0_addr, rf_rd1_addr, rf_wr_en}, {2'd1, 2'd2, 1'b0});
    tick();
    checkOutput("t3_c3", {alu_op, rf_rd0_addr, rf_rd1_addr, rf_wr_en}, {3'b001, 2'd1, 2'd2, 1'b0});
    tick();
    checkOutput("t3_c4_wb", {rf_wr_en, rf_wr_addr, alu_op, imm_sel, instr_ready},
                {1'b1, 2'd3, 3'b001, 1'b0, 1'b0});
    tick();
    expRetired++;
    checkOutput("t3_c5", {rf_wr_en, instr_ready}, 2'b01);
    checkOutput("t3_retired", retired_cnt, expRetired[CNT_W-1:0]);
    tick();
    instr_valid = 1'b0;
    checkOutput("t3_reaccept", {busy, instr_ready}, 2'b10);
    tick(); tick(); tick(); tick();
    expRetired++;
    checkOutput("t3_retired2", retired_cnt, expRetired[CNT_W-1:0]);

    // 4: NOP, CLR, SUB back to back
    wrBase  = wrEnCount;
    clrBase = clrCount;
    applyStimulus(W_NOP, "t4_nop");
    applyStimulus(W_CLR, "t4_clr");
    applyStimulus(W_SUB, "t4_sub");
    waitReady("t4_done");
    tick();
    expRetired += 3;
    checkOutput("t4_retired", retired_cnt, expRetired[CNT_W-1:0]);
    checkOutput("t4_clr_once", clrCount - clrBase, 1);
    checkOutput("t4_sub_write", wrEnCount - wrBase, 1);
    checkOutput("t4_sub_dst", rf_wr_addr, 2'd1);
    checkOutput("t4_exclusive", bothHigh, 0);

    // 5: HALT ignores words until start
    wrBase = wrEnCount;
    applyStimulus(W_HALT, "t5_halt");
    tick();
    expRetired++;
    instr_valid = 1'b1;
    instr_data  = W_NOP;
    checkOutput("t5_halted", {halted, instr_ready, busy}, 3'b100);
    tick(); tick(); tick();
    checkOutput("t5_still", {halted, instr_ready}, 2'b10);
    checkOutput("t5_retired", retired_cnt, expRetired[CNT_W-1:0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("t5_idle", {halted, instr_ready, busy}, 3'b010);
    tick();
    instr_valid = 1'b0;
    checkOutput("t5_accept", busy, 1);
    tick();
    expRetired++;
    checkOutput("t5_nop_retired", retired_cnt, expRetired[CNT_W-1:0]);
    checkOutput("t5_no_write", wrEnCount - wrBase, 0);

    // 6: counter wrap with 4-bit counter
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(W_NOP, "t6_nop");
    tick();
    checkOutput("t6_wrap", retired_cnt, 1);
    checkOutput("t6_exclusive", bothHigh, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rf_seq_ctrl.md
Name: rf_seq_ctrl

Overview:
Multi-cycle sequencer driving the 4x9-bit register file and ALU. Accepts 10-bit instruction words over a valid/ready handshake, decodes them, and sequences read, execute and write-back. All register-file and ALU control comes from this block; the ALU result / immediate mux sits outside it.

Parameters:
INSTR_W, 10, instruction word width (fixed encoding below; not to be changed)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction/immediate word available
instr_ready  out  1  block accepts word this cycle
instr_data  in  INSTR_W  instruction or immediate word
start  in  1  one-cycle pulse, leaves HALT
rf_rd0_addr  out  2  register file read port 0 address
rf_rd1_addr  out  2  register file read port 1 address
rf_wr_addr  out  2  register file write address
rf_wr_en  out  1  register file write enable
rf_clr  out  1  register file clear request (active-high)
alu_op  out  3  ALU operation select
imm_sel  out  1  1 = write-back data taken from imm_data, 0 = from ALU
imm_data  out  9  immediate for LDI
busy  out  1  high in any state except IDLE and HALT
halted  out  1  high in HALT
retired_cnt  out  CNT_W  count of completed instructions

Behaviour:
- Encoding: op=[9:7], dst=[6:5], src0=[4:3], src1=[2:1], flag=[0].
- Opcodes: 000 NOP; 001 ADD; 010 SUB; 011 AND; 100 OR; 101 NOT (src0 only); 110 LDI (the next word's [8:0] is the immediate); 111 with flag=0 HALT, with flag=1 CLR.
- Reset (async on rst_n low): state IDLE. All rf_*, alu_op, imm_sel, imm_data = 0. retired_cnt = 0. halted = 0, busy = 0. instr_ready = 0 while in reset.
- Reset mid-operation aborts the instruction with no write.
- States: IDLE, DECODE, IMM, READ, EXEC, WB, CLR, HALT.
- IDLE: instr_ready=1. A transfer occurs when instr_valid & instr_ready at a posedge. On transfer, latch the word and go to DECODE.
- DECODE, by op:
  - NOP -> IDLE; retires.
  - ALU ops -> READ.
  - LDI -> IMM.
  - HALT -> HALT; retires.
  - CLR -> CLR.
- IMM: instr_ready=1. Wait any number of cycles for the handshake. On transfer, latch [8:0] to imm_data, then go to WB with imm_sel=1.
- READ (1 cycle): drive rf_rd0_addr=src0 and rf_rd1_addr=src1, with rf_wr_en=0. Read data must be valid by the end of this cycle.
- EXEC (1 cycle): read addresses held, alu_op=op, rf_wr_en=0.
- WB (1 cycle):
  - rf_wr_en=1, rf_wr_addr=dst.
  - Read addresses and alu_op held.
  - Next state IDLE; retired_cnt increments.
- CLR (1 cycle): rf_clr=1, rf_wr_en=0, then IDLE; retires.
- HALT: instr_ready=0, halted=1. start moves to IDLE. start in any other state is ignored.
- rf_wr_en and rf_clr are never high together. Each is high for exactly one cycle per instruction.
- instr_ready is high only in IDLE and IMM.
- Latency, acceptance cycle = 0:
  - ALU op: write at cycle 4, instr_ready again at cycle 5.
  - LDI with immediate at cycle k: write at k+1.
- retired_cnt wraps modulo 2^CNT_W.
- imm_sel returns to 0 on leaving WB.
- Outputs are registered; no combinational path from instr_* to rf_*.

Decomposition:
- Shared package rf_pkg: opcode localparams (OP_NOP..OP_SYS), state encoding, field bit-position constants, REG_W=9, ADDR_W=2.
- One natural sub-module, rf_seq_decode: combinational field extraction and next-state class.

Test Plan:
1. Reset: rst_n low mid-EXEC of ADD -> rf_wr_en never asserts; all outputs 0; retired_cnt=0 after release.
2. LDI r2 = 9'h1A5: instr 10'b110_10_00_00_0, then immediate after a 3-cycle valid gap -> instr_ready stays high in IMM; one cycle with rf_wr_en=1, rf_wr_addr=2, imm_sel=1, imm_data=9'h1A5.
3. ADD r3=r1+r2 (10'b001_11_01_10_0) with valid held high -> rd0=1 and rd1=2 from cycle 2; alu_op=001; rf_wr_en at cycle 4 only; next accept at cycle 5.
4. Back-to-back NOP, CLR, SUB -> retired_cnt=3; rf_clr pulses once; rf_clr and rf_wr_en never high together.
5. HALT then valid words -> halted=1, instr_ready=0, no writes; start pulse -> IDLE, pending word accepted next cycle.
6. Counter wrap with CNT_W=4: 17 NOPs -> retired_cnt=1.
